// File: rtl/matrix_scan_controller.sv
// matrix_scan_controller
// Column sequencer for a 7-column x 5-row LED matrix. Generates active-low
// one-hot column strobes with a fixed dwell per column, and single-cycle
// shift/load strobes for the row pattern registers, all as clock enables
// on one clock domain.
//
// Build option: define GHOST_BLANK_EN to blank every column (7'h7F) for the
// first cycle of its dwell, giving an anti-ghosting dead time between columns.
//
// Mode (ch1,ch0), resynchronised and applied only at frame boundaries:
//   00 static (offset forced to 0), 01 scroll left, 10 scroll right,
//   11 freeze (offset held, no strobes).
//
// After reset release, the first clock edge opens a one-cycle LOAD window
// (load=1, columns dark). The next edge starts column 0 of the first frame.
module matrix_scan_controller #(
  parameter int DWELL           = 5000,
  parameter int FRAMES_PER_STEP = 25,
  parameter int MSG_LEN         = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ch1,
  input  logic                       ch0,
  output logic [6:0]                 acender_coluna,
  output logic [2:0]                 col_idx,
  output logic                       shift_en,
  output logic                       shift_dir,
  output logic                       load,
  output logic [$clog2(MSG_LEN)-1:0] offset,
  output logic                       frame_start,
  output logic [1:0]                 mode_q
);

  localparam int DW = $clog2(DWELL);
  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int OW = $clog2(MSG_LEN);

  localparam logic [DW-1:0] DWELL_LAST  = DW'(DWELL - 1);
  localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAMES_PER_STEP - 1);
  localparam logic [OW-1:0] OFFSET_LAST = OW'(MSG_LEN - 1);
  localparam logic [2:0]    COL_LAST    = 3'd6;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_LEFT   = 2'b01;
  localparam logic [1:0] MODE_RIGHT  = 2'b10;

  typedef enum logic {
    LOAD = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    sync_meta;
  logic [1:0]    mode_s;
  logic [DW-1:0] dwell_cnt;
  logic [FW-1:0] frame_cnt;
  logic          col_end;
  logic          frame_end;

  assign col_end   = (dwell_cnt == DWELL_LAST);
  assign frame_end = (state == SCAN) && col_end && (col_idx == COL_LAST);

  // Two-flop synchroniser for the asynchronous mode switches.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 2'b00;
      mode_s    <= 2'b00;
    end else begin
      sync_meta <= {ch1, ch0};
      mode_s    <= sync_meta;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  // Next state and column drive.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves a value unassigned and infers a latch.
  always_comb begin
    state_next     = state;
    acender_coluna = 7'h7F;
    if (state == LOAD) begin
      // Leave LOAD on the edge after the load strobe has been shown.
      if (load) state_next = SCAN;
    end else begin
      acender_coluna = ~(7'b1000000 >> col_idx);
`ifdef GHOST_BLANK_EN
      if (dwell_cnt == '0) acender_coluna = 7'h7F;
`endif
    end
  end

  // Dwell/column timing, frame-boundary mode handling and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt   <= '0;
      col_idx     <= 3'd0;
      frame_cnt   <= '0;
      offset      <= '0;
      mode_q      <= MODE_STATIC;
      shift_en    <= 1'b0;
      shift_dir   <= 1'b0;
      load        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      shift_en    <= 1'b0;
      load        <= 1'b0;
      frame_start <= 1'b0;

      if (state == LOAD) begin
        // First edge raises load; second edge drops it and opens column 0.
        load      <= ~load;
        dwell_cnt <= '0;
        col_idx   <= 3'd0;
        if (load) frame_start <= 1'b1;
      end else if (!col_end) begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end else begin
        dwell_cnt <= '0;
        if (!frame_end) begin
          col_idx <= col_idx + 3'd1;
        end else begin
          col_idx     <= 3'd0;
          frame_start <= 1'b1;
          mode_q      <= mode_s;
          if (mode_s != mode_q) begin
            // A new mode restarts the step timer; entering static also
            // rewinds the pattern.
            frame_cnt <= '0;
            if (mode_s == MODE_STATIC) begin
              load   <= 1'b1;
              offset <= '0;
            end
          end else if (mode_q == MODE_LEFT || mode_q == MODE_RIGHT) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= '0;
              shift_en  <= 1'b1;
              shift_dir <= mode_q[0];
              if (mode_q == MODE_LEFT)
                offset <= (offset == OFFSET_LAST) ? '0 : offset + 1'b1;
              else
                offset <= (offset == '0) ? OFFSET_LAST : offset - 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end else begin
            frame_cnt <= '0;
          end
        end
      end
    end
  end

endmodule
